// File: rtl/spi_master_core.sv
// Single-byte SPI master, mode 0, with a clk/(2*CLK_DIV) SCK and registered outputs.
// Optional build macro SPI_MASTER_LSB_FIRST_EN switches both shift directions to LSB first.
module spi_master_core #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       miso,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       mosi,
  output logic       sck,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       new_data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             new_data_q, new_data_d;

  logic             tick_s;
  logic             first_bit_s;
  logic [7:0]       tx_rot_s;
  logic             tx_next_s;
  logic [7:0]       rx_shift_s;

  // tx is rotated rather than shifted: only eight bits are ever consumed per byte.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign first_bit_s = data_in[0];
  assign tx_rot_s    = {tx_q[0], tx_q[7:1]};
  assign tx_next_s   = tx_rot_s[0];
  assign rx_shift_s  = {miso, rx_q[7:1]};
`else
  assign first_bit_s = data_in[7];
  assign tx_rot_s    = {tx_q[6:0], tx_q[7]};
  assign tx_next_s   = tx_rot_s[7];
  assign rx_shift_s  = {rx_q[6:0], miso};
`endif

  assign tick_s = (state_q == XFER) && (div_q == DIV_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        // Falling SCK edge after the eighth rising edge ends the byte.
        if (tick_s && sck_q && (bit_cnt_q == 4'd8)) begin
          state_d = DONE;
        end else begin
          state_d = XFER;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    new_data_d = 1'b0;
    case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          tx_d      = data_in;
          mosi_d    = first_bit_s;
          busy_d    = 1'b1;
          bit_cnt_d = 4'd0;
          div_d     = '0;
        end else begin
          div_d = '0;
        end
      end
      XFER: begin
        if (tick_s) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d      = rx_shift_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q != 4'd8) begin
            tx_d   = tx_rot_s;
            mosi_d = tx_next_s;
          end else begin
            mosi_d = mosi_q;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        data_out_d = rx_q;
        new_data_d = 1'b1;
        busy_d     = 1'b0;
        sck_d      = 1'b0;
        mosi_d     = 1'b0;
      end
      default: begin
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        div_d  = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      bit_cnt_q  <= 4'd0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      data_out_q <= 8'h00;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      new_data_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      new_data_q <= new_data_d;
    end
  end

  assign mosi     = mosi_q;
  assign sck      = sck_q;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign new_data = new_data_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: event logs of SCK rises and new_data
// pulses are compared against a bit-list reference model of the SPI byte exchange.
`timescale 1ns/1ps
module tb_spi_master_core;

  localparam int CLK_DIV = 4;
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       miso = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       mosi, sck, busy, new_data;
  logic [7:0] data_out;

  spi_master_core #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .miso(miso), .start(start), .data_in(data_in),
    .mosi(mosi), .sck(sck), .data_out(data_out), .busy(busy), .new_data(new_data)
  );

  always #19.231 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         miso_mode = 0;   // 0 constant, 1 toggle on SCK fall, 2 random on SCK fall
  logic       prev_sck = 1'b0;
  int         rise_cyc_q[$];
  logic       mosi_q[$];
  logic       miso_q[$];
  int         nd_cyc_q[$];
  logic [7:0] nd_data_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event monitor: edge count plus line values at each SCK rise and new_data pulse
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (sck && !prev_sck) begin
      rise_cyc_q.push_back(cyc);
      mosi_q.push_back(mosi);
      miso_q.push_back(miso);
    end
    prev_sck = sck;
    if (new_data) begin
      nd_cyc_q.push_back(cyc);
      nd_data_q.push_back(data_out);
    end
  end

  // Slave model: updates miso after each SCK falling edge
  always @(negedge sck) begin
    if (miso_mode == 1) miso = ~miso;
    else if (miso_mode == 2) miso = 1'($urandom);
  end

  function automatic logic [7:0] pack_bits(input logic bits[$]);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8 && i < bits.size(); i++) begin
      if (LSB_FIRST) v[i] = bits[i];
      else v[7-i] = bits[i];
    end
    return v;
  endfunction

  task automatic clear_logs();
    rise_cyc_q.delete(); mosi_q.delete(); miso_q.delete();
    nd_cyc_q.delete(); nd_data_q.delete();
  endtask

  task automatic wait_nd(input int n, input int budget, input string tag);
    int k = 0;
    while (nd_cyc_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (nd_cyc_q.size() < n) check_eq({tag, "_timeout"}, nd_cyc_q.size(), n);
  endtask

  // One transfer; called just after a falling clk edge with the DUT idle
  task automatic run_one(input string tag, input logic [7:0] d, input int mmode,
                         input logic init_miso, input bit mid_change);
    int  acc;
    bit  t_ok;
    logic [7:0] exp_rx;
    clear_logs();
    miso_mode = mmode;
    miso = init_miso;
    data_in = d;
    start = 1'b1;
    acc = cyc + 1;
    if (!mid_change) begin
      @(negedge clk);
      start = 1'b0;
      data_in = 8'($urandom);
    end else begin
      for (int k = 0; k < 40 && rise_cyc_q.size() < 3; k++) @(negedge clk);
      start = 1'b0;
      data_in = 8'h00;
    end
    wait_nd(1, 90, tag);
    @(negedge clk);
    exp_rx = pack_bits(miso_q);
    t_ok = (rise_cyc_q.size() == 8);
    for (int i = 0; i < rise_cyc_q.size(); i++)
      if (rise_cyc_q[i] != acc + 2*CLK_DIV*i + CLK_DIV) t_ok = 1'b0;
    check_eq({tag, "_sck_pulses"}, rise_cyc_q.size(), 8);
    check_eq({tag, "_sck_timing"}, 32'(t_ok), 32'd1);
    check_eq({tag, "_mosi"}, pack_bits(mosi_q), d);
    check_eq({tag, "_nd_count"}, nd_cyc_q.size(), 1);
    if (nd_cyc_q.size() > 0) begin
      check_eq({tag, "_nd_latency"}, nd_cyc_q[0] - acc, 16*CLK_DIV + 1);
      check_eq({tag, "_nd_data"}, nd_data_q[0], exp_rx);
    end
    check_eq({tag, "_busy_after"}, busy, 1'b0);
    check_eq({tag, "_data_hold"}, data_out, exp_rx);
  endtask

  initial begin
    // Reset with start requested
    rst = 1'b0; start = 1'b1; data_in = 8'hD4;
    repeat (4) @(negedge clk);
    check_eq("rst_sck", sck, 1'b0);
    check_eq("rst_mosi", mosi, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_new_data", new_data, 1'b0);
    check_eq("rst_data_out", data_out, 8'h00);

    // Single byte accepted on the first edge after reset release
    rst = 1'b1;
    run_one("single", 8'hD4, 1, 1'b1, 1'b0);
    check_eq("single_AA", data_out, LSB_FIRST ? 8'h55 : 8'hAA);

    // Mid-transfer input changes
    @(negedge clk);
    run_one("midchg", 8'hD4, 1, 1'b1, 1'b1);
    check_eq("midchg_AA", data_out, LSB_FIRST ? 8'h55 : 8'hAA);

    // Constant miso levels
    @(negedge clk);
    run_one("const1", 8'hD4, 0, 1'b1, 1'b0);
    check_eq("const1_FF", data_out, 8'hFF);
    @(negedge clk);
    run_one("const0", 8'hD4, 0, 1'b0, 1'b0);
    check_eq("const0_00", data_out, 8'h00);

    // Randomized bytes and slave behaviour
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      run_one($sformatf("rand%0d", r), 8'($urandom), int'($urandom_range(0, 2)),
              1'($urandom), 1'b0);
    end

    // start held high: back-to-back transfers
    @(negedge clk);
    clear_logs();
    miso_mode = 1; miso = 1'b1; data_in = 8'hD4; start = 1'b1;
    begin
      int acc;
      acc = cyc + 1;
      wait_nd(3, 250, "b2b");
      start = 1'b0;
      check_eq("b2b_rises", rise_cyc_q.size(), 24);
      if (nd_cyc_q.size() >= 3) begin
        check_eq("b2b_first_latency", nd_cyc_q[0] - acc, 16*CLK_DIV + 1);
        check_eq("b2b_gap1", nd_cyc_q[1] - nd_cyc_q[0], 16*CLK_DIV + 2);
        check_eq("b2b_gap2", nd_cyc_q[2] - nd_cyc_q[1], 16*CLK_DIV + 2);
        for (int i = 0; i < 3; i++)
          check_eq($sformatf("b2b_data%0d", i), nd_data_q[i], LSB_FIRST ? 8'h55 : 8'hAA);
      end
      repeat (80) @(negedge clk);
      check_eq("b2b_stopped", nd_cyc_q.size(), 3);
      check_eq("b2b_busy_idle", busy, 1'b0);
    end

    // Reset abort after the 4th SCK rise
    clear_logs();
    miso_mode = 1; miso = 1'b1; data_in = 8'hD4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60 && rise_cyc_q.size() < 4; k++) @(negedge clk);
    check_eq("abort_rises_seen", rise_cyc_q.size(), 4);
    rst = 1'b0;
    #1;
    check_eq("abort_sck", sck, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_mosi", mosi, 1'b0);
    check_eq("abort_data_out", data_out, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    check_eq("abort_no_nd", nd_cyc_q.size(), 0);
    check_eq("abort_data_out_after", data_out, 8'h00);
    check_eq("abort_busy_after", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
